// File: rtl/sensor_sequence_generator_if.sv
// Command/sensor bundle between a passage source (master) and the generator (slave).
interface sensor_sequence_generator_if;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic       cmd_ready;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic [1:0] cur_type;

    modport master (
        output cmd_valid, cmd_type,
        input  cmd_ready, a, b, busy, done, cur_type
    );
    modport slave (
        input  cmd_valid, cmd_type,
        output cmd_ready, a, b, busy, done, cur_type
    );
endinterface

// File: rtl/sensor_sequence_generator.sv
// Drives the a/b parking-sensor waveform for one car passage per accepted command
// (entry, exit, or a backed-out entry/exit), followed by an idle gap.
module sensor_sequence_generator #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    sensor_sequence_generator_if.slave  bus
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    type_q, type_n;
    logic [1:0]    ab_q, ab_n;
    logic          busy_q, done_q;
    logic          accept;

    // PH3 repeats PH1 for a backed-out car, otherwise the sensor that tripped first clears first.
    function automatic logic [1:0] pattern(input logic [1:0] t, input state_t s);
        logic [1:0] first;
        first = t[0] ? 2'b01 : 2'b10;
        case (s)
            PH1:     pattern = first;
            PH2:     pattern = 2'b11;
            PH3:     pattern = t[1] ? first : {first[0], first[1]};
            default: pattern = 2'b00;
        endcase
    endfunction

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        type_n  = type_q;
        case (state)
            IDLE: if (accept) begin
                state_n = PH1;
                cnt_n   = HOLD_LD;
                type_n  = bus.cmd_type;
            end
            PH1, PH2: begin
                if (cnt == '0) begin
                    state_n = (state == PH1) ? PH2 : PH3;
                    cnt_n   = HOLD_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            PH3: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        ab_n = pattern(type_n, state_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            type_q <= 2'b00;
            ab_q   <= 2'b00;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            type_q <= type_n;
            ab_q   <= ab_n;
            busy_q <= (state_n != IDLE);
            done_q <= (state == GAP) && (cnt == '0);
        end
    end

    assign bus.a        = ab_q[1];
    assign bus.b        = ab_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cur_type = type_q;
endmodule

// File: tb/tb_sensor_sequence_generator.sv
// Bench: directed + randomized passages checked against a timing/pattern model and a
// behavioural S/R decoder that classifies the observed a/b trace.
module tb_sensor_sequence_generator;
    localparam int H  = 4;
    localparam int G  = 2;
    localparam int L  = 3 * H + G + 1;
    localparam int L1 = 3 * 1 + 1 + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sensor_sequence_generator_if bus ();
    sensor_sequence_generator_if bus1 ();

    sensor_sequence_generator #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    sensor_sequence_generator #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // {a,b,busy,done,cmd_ready} k cycles after the acceptance edge
    function automatic logic [4:0] exp_out(input logic [1:0] t, input int k, input int h, input int g);
        logic [1:0] p1, p3;
        case (t)
            2'b00:   begin p1 = 2'b10; p3 = 2'b01; end
            2'b01:   begin p1 = 2'b01; p3 = 2'b10; end
            2'b10:   begin p1 = 2'b10; p3 = 2'b10; end
            default: begin p1 = 2'b01; p3 = 2'b01; end
        endcase
        if (k <= h)         return {p1, 3'b100};
        if (k <= 2 * h)     return {2'b11, 3'b100};
        if (k <= 3 * h)     return {p3, 3'b100};
        if (k <= 3 * h + g) return {2'b00, 3'b100};
        if (k == 3 * h + g + 1) return 5'b00011;
        return 5'b00001;
    endfunction

    // Decoder view of a passage: {S,R}
    function automatic logic [1:0] classify(input logic [1:0] trace[$]);
        logic [1:0] seen[$];
        foreach (trace[i])
            if (trace[i] != 2'b00 && (seen.size() == 0 || seen[seen.size()-1] != trace[i]))
                seen.push_back(trace[i]);
        if (seen.size() == 3 && seen[0] == 2'b10 && seen[1] == 2'b11 && seen[2] == 2'b01) return 2'b10;
        if (seen.size() == 3 && seen[0] == 2'b01 && seen[1] == 2'b11 && seen[2] == 2'b10) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_sr(input logic [1:0] t);
        return (t == 2'b00) ? 2'b10 : (t == 2'b01) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [4:0] obs0();
        return {bus.a, bus.b, bus.busy, bus.done, bus.cmd_ready};
    endfunction

    task automatic start(input logic [1:0] t);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
    endtask

    // Caller has presented t while ready; consumes acceptance edge through done cycle.
    task automatic run(input logic [1:0] t, input bit b2b, input logic [1:0] nt);
        logic [1:0] trace[$];
        @(posedge clk);
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            chk("passage", k, {3'b0, obs0()}, {3'b0, exp_out(t, k, H, G)});
            trace.push_back({bus.a, bus.b});
            if (k < L) begin
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_type  = 2'($urandom_range(0, 3));
            end else begin
                chk("cur_type", k, {6'b0, bus.cur_type}, {6'b0, t});
                bus.cmd_valid = b2b;
                bus.cmd_type  = nt;
            end
        end
        chk("decode_sr", L, {6'b0, classify(trace)}, {6'b0, exp_sr(t)});
    endtask

    task automatic idle_chk(input int n, input logic [1:0] ct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle", i, {1'b0, obs0(), bus.cur_type}, {1'b0, 5'b00001, ct});
        end
    endtask

    initial begin
        logic [1:0] t, nt;
        bit b2b;
        logic [1:0] trace1[$];

        rst = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_type   = 2'b00;
        bus1.cmd_valid = 1'b0;
        bus1.cmd_type  = 2'b00;
        #1;
        chk("reset", 0, {1'b0, obs0(), bus.cur_type}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 0, {3'b0, obs0()}, 8'h01);

        // entry, then exit with cur_type retained
        start(2'b00); run(2'b00, 1'b0, 2'b00);
        idle_chk(2, 2'b00);
        start(2'b01); run(2'b01, 1'b0, 2'b00);
        idle_chk(3, 2'b01);

        // aborted entry, then aborted exit accepted on the done cycle
        start(2'b10); run(2'b10, 1'b1, 2'b11);
        run(2'b11, 1'b0, 2'b00);
        idle_chk(1, 2'b11);

        // entry with noise while busy, exit held valid and taken on the done cycle
        start(2'b00); run(2'b00, 1'b1, 2'b01);
        run(2'b01, 1'b0, 2'b00);
        idle_chk(2, 2'b01);

        // asynchronous reset mid-passage
        start(2'b00);
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        chk("pre_reset_ab", 7, {6'b0, bus.a, bus.b}, 8'h03);
        #2 rst = 1'b1;
        #1 chk("mid_reset", 7, {1'b0, obs0(), bus.cur_type}, 8'h00);
        @(negedge clk);
        chk("reset_held", 8, {1'b0, obs0(), bus.cur_type}, 8'h00);
        rst = 1'b0;
        idle_chk(2, 2'b00);
        start(2'b00); run(2'b00, 1'b0, 2'b00);
        idle_chk(1, 2'b00);

        // randomized passages, mix of back-to-back and spaced commands
        t = 2'($urandom_range(0, 3));
        start(t);
        for (int i = 0; i < 8; i++) begin
            nt  = 2'($urandom_range(0, 3));
            b2b = (i < 7) && ($urandom_range(0, 1) == 1);
            run(t, b2b, nt);
            if (!b2b && i < 7) begin
                idle_chk($urandom_range(1, 3), t);
                start(nt);
            end
            t = nt;
        end
        idle_chk(1, t);

        // HOLD=1, GAP=1 corner: entry then exit back-to-back
        for (int p = 0; p < 2; p++) begin
            t = 2'(p);
            trace1.delete();
            bus1.cmd_valid = 1'b1;
            bus1.cmd_type  = t;
            @(posedge clk);
            for (int k = 1; k <= L1; k++) begin
                @(negedge clk);
                bus1.cmd_valid = 1'b0;
                chk("corner", k, {3'b0, bus1.a, bus1.b, bus1.busy, bus1.done, bus1.cmd_ready},
                    {3'b0, exp_out(t, k, 1, 1)});
                trace1.push_back({bus1.a, bus1.b});
            end
            chk("corner_sr", p, {6'b0, classify(trace1)}, {6'b0, exp_sr(t)});
            chk("corner_cur", p, {6'b0, bus1.cur_type}, {6'b0, t});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sensor_sequence_generator.md
Name: sensor_sequence_generator

Overview:
- Emulates the two parking-lot sensors (a, b) for a single car passage.
- Takes one command per passage and drives the a/b waveform that the estacionamiento control FSM decodes into an entry pulse (S) or an exit pulse (R).
- Also drives aborted passages, where a car backs out, so the FSM can be shown to produce no S or R pulse.
- Used as the stimulus source in demo boards and in the system bench, connected directly to the FSM's a/b inputs.

Parameters:
- HOLD_CYCLES, 4, clock cycles each non-idle sensor phase is held; must be >= 1 (elaboration error otherwise).
- GAP_CYCLES, 2, clock cycles a=b=0 is held after the last active phase before done; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- cmd_valid  input  1  a command is presented on cmd_type.
- cmd_type  input  2  00 entry, 01 exit, 10 aborted entry, 11 aborted exit.
- cmd_ready  output  1  high only in IDLE with rst low; a command is accepted on a clk edge where cmd_valid & cmd_ready.
- a  output  1  emulated sensor 1 (registered).
- b  output  1  emulated sensor 2 (registered).
- busy  output  1  high from the cycle after acceptance until the last gap cycle, inclusive.
- done  output  1  one-cycle pulse when a passage completes.
- cur_type  output  2  type latched at acceptance; holds its value after completion; 00 after reset.

Behaviour:
- Reset (asynchronous): state IDLE; a=0, b=0, busy=0, done=0, cur_type=00, phase counter=0. cmd_ready=1 once rst deasserts.
- FSM states: IDLE, PH1, PH2, PH3, GAP. A phase counter counts down from HOLD_CYCLES-1 in PH1..PH3 and from GAP_CYCLES-1 in GAP; the state advances when the counter is 0.
- Sensor patterns per phase, given as {a,b}:
  - entry: PH1=10, PH2=11, PH3=01
  - exit: PH1=01, PH2=11, PH3=10
  - aborted entry: PH1=10, PH2=11, PH3=10
  - aborted exit: PH1=01, PH2=11, PH3=01
  - GAP=00 for all types.
- Acceptance edge: cmd_type is latched into cur_type and the state goes IDLE->PH1. a/b show the PH1 pattern starting the cycle after acceptance.
- Each of PH1..PH3 lasts exactly HOLD_CYCLES cycles. GAP lasts exactly GAP_CYCLES cycles.
- Completion: GAP->IDLE. In the first IDLE cycle, done=1 (for one cycle only) and cmd_ready=1.
- Back-to-back commands: a command may be accepted in the same cycle as done. The next PH1 then starts the following cycle, and the decoder still sees at least GAP_CYCLES idle cycles between passages.
- Latency: acceptance edge to done cycle = 3*HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- Command while busy: cmd_ready=0; the command is ignored, not queued. Upstream holds cmd_valid until accepted.
- cmd_type changes after acceptance have no effect on the passage in progress.
- Reset mid-passage: a=b=0 immediately, no done pulse, cur_type=00. The partial passage is abandoned, and the decoder must return to its idle state on the next 00 sample.
- a and b change only on clock edges, except under reset. a and b never change on the same edge in a way that skips the 11 phase; the pattern is Gray-like, one sensor at a time, except PH1/GAP boundaries, which change one bit only.
- All counters are sized ceil(log2(max(HOLD_CYCLES,GAP_CYCLES)+1)) bits; no wrap-around is possible within a phase.

Test Plan:
- Reset then entry command, cmd_type=00 accepted at cycle 0 (HOLD=4, GAP=2):
  - {a,b}=10 on cycles 1-4, 11 on 5-8, 01 on 9-12, 00 on 13-14.
  - done=1 only on cycle 15; busy high on cycles 1-14.
  - Connected control FSM pulses S exactly once and R never.
- Exit command, cmd_type=01: {a,b} sequence 01,11,10,00 with the same timing -> FSM pulses R once, S never; cur_type=01 after completion.
- Aborted entry (10) then aborted exit (11), issued back-to-back with the second accepted on the done cycle of the first:
  - sequences 10,11,10,00 then 01,11,01,00.
  - FSM pulses neither S nor R.
  - Second passage's PH1 starts the cycle after the first done.
- Command during busy: cmd_valid pulsed with cmd_type=01 at cycle 6 of an entry -> ignored, and the entry sequence is unchanged. The command held valid until cycle 15 is accepted at cycle 15.
- Reset asserted asynchronously at cycle 7 of an entry -> a=b=0 and busy=0 before the next edge, no done pulse, cur_type=00. An entry issued after reset release yields exactly one S pulse.
- Parameter corner HOLD=1, GAP=1: entry accepted at cycle 0 -> 10,11,01,00 on cycles 1,2,3,4, done on cycle 5 -> FSM pulses S once.
